// File: rtl/cnn_phase_scheduler.sv
// Schedules the CNN feature-extraction datapath through the CONV, POOL and FLAT phases.
// Define CNN_SCHED_PERF_EN to add the stall_cycles performance counter output.
module cnn_phase_scheduler #(
  parameter int IMAGE_WIDTH  = 12,
  parameter int IMAGE_HEIGHT = 12,
  parameter int KERNEL_SIZE  = 3,
  localparam int CONV_W = IMAGE_WIDTH - KERNEL_SIZE + 1,
  localparam int CONV_H = IMAGE_HEIGHT - KERNEL_SIZE + 1,
  localparam int POOL_W = CONV_W >> 1,
  localparam int POOL_H = CONV_H >> 1,
  localparam int FLAT_N = POOL_W * POOL_H,
  localparam int RW     = $clog2(CONV_H),
  localparam int CW     = $clog2(CONV_W),
  localparam int FW     = $clog2(FLAT_N),
  localparam int PRW    = $clog2(POOL_H),
  localparam int PCW    = $clog2(POOL_W)
) (
  input  logic           clk,
  input  logic           rst_cnn,
  input  logic           start_n,
  input  logic           weights_ready,
  input  logic           stall,
  output logic [2:0]     phase,
  output logic           busy,
  output logic           conv_valid,
  output logic [RW-1:0]  conv_row,
  output logic [CW-1:0]  conv_col,
  output logic           pool_valid,
  output logic           pool_last,
  output logic [PRW-1:0] pool_row,
  output logic [PCW-1:0] pool_col,
  output logic           flat_valid,
  output logic [FW-1:0]  flat_index,
  output logic           done
`ifdef CNN_SCHED_PERF_EN
  ,
  output logic [15:0]    stall_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CONV = 3'd1,
    S_POOL = 3'd2,
    S_FLAT = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [RW-1:0]  conv_row_q, conv_row_d;
  logic [CW-1:0]  conv_col_q, conv_col_d;
  logic [PRW-1:0] pool_row_q, pool_row_d;
  logic [PCW-1:0] pool_col_q, pool_col_d;
  logic [1:0]     sub_q, sub_d;
  logic [FW-1:0]  flat_q, flat_d;
  logic           conv_vld_q, conv_vld_d;
  logic           pool_vld_q, pool_vld_d;
  logic           pool_last_q, pool_last_d;
  logic           flat_vld_q, flat_vld_d;
  logic           done_q, done_d;
  logic           pool_col_end, pool_row_end;

  assign pool_col_end = (pool_col_q == PCW'(POOL_W - 1));
  assign pool_row_end = (pool_row_q == PRW'(POOL_H - 1));

  always_comb begin
    state_d     = state_q;
    conv_row_d  = conv_row_q;
    conv_col_d  = conv_col_q;
    pool_row_d  = pool_row_q;
    pool_col_d  = pool_col_q;
    sub_d       = sub_q;
    flat_d      = flat_q;
    conv_vld_d  = 1'b0;
    pool_vld_d  = 1'b0;
    pool_last_d = 1'b0;
    flat_vld_d  = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!start_n && weights_ready) begin
          state_d    = S_CONV;
          conv_row_d = '0;
          conv_col_d = '0;
          pool_row_d = '0;
          pool_col_d = '0;
          sub_d      = '0;
          flat_d     = '0;
          conv_vld_d = 1'b1;
        end
      end
      S_CONV: begin
        if (!stall) begin
          if (conv_col_q == CW'(CONV_W - 1)) begin
            conv_col_d = '0;
            if (conv_row_q == RW'(CONV_H - 1)) begin
              // First pool read addresses conv (0,0) of the now-final map.
              state_d    = S_POOL;
              conv_row_d = '0;
              sub_d      = '0;
              pool_row_d = '0;
              pool_col_d = '0;
              pool_vld_d = 1'b1;
            end else begin
              conv_row_d = conv_row_q + RW'(1);
              conv_vld_d = 1'b1;
            end
          end else begin
            conv_col_d = conv_col_q + CW'(1);
            conv_vld_d = 1'b1;
          end
        end
      end
      S_POOL: begin
        if (!stall) begin
          if (sub_q == 2'd3) begin
            sub_d = 2'd0;
            if (pool_row_end && pool_col_end) begin
              state_d    = S_FLAT;
              pool_row_d = '0;
              pool_col_d = '0;
              flat_d     = '0;
              flat_vld_d = 1'b1;
            end else begin
              pool_vld_d = 1'b1;
              if (pool_col_end) begin
                pool_col_d = '0;
                pool_row_d = pool_row_q + PRW'(1);
              end else begin
                pool_col_d = pool_col_q + PCW'(1);
              end
            end
          end else begin
            sub_d      = sub_q + 2'd1;
            pool_vld_d = 1'b1;
          end
          // Sub-step bits select the row/column offset inside the 2x2 window.
          if (pool_vld_d) begin
            conv_row_d  = RW'(2 * int'(pool_row_d) + int'(sub_d[1]));
            conv_col_d  = CW'(2 * int'(pool_col_d) + int'(sub_d[0]));
            pool_last_d = (sub_d == 2'd3);
          end
        end
      end
      S_FLAT: begin
        if (!stall) begin
          if (flat_q == FW'(FLAT_N - 1)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            flat_d     = flat_q + FW'(1);
            flat_vld_d = 1'b1;
            if (pool_col_end) begin
              pool_col_d = '0;
              pool_row_d = pool_row_q + PRW'(1);
            end else begin
              pool_col_d = pool_col_q + PCW'(1);
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst_cnn) begin
    if (!rst_cnn) begin
      state_q     <= S_IDLE;
      conv_row_q  <= '0;
      conv_col_q  <= '0;
      pool_row_q  <= '0;
      pool_col_q  <= '0;
      sub_q       <= '0;
      flat_q      <= '0;
      conv_vld_q  <= 1'b0;
      pool_vld_q  <= 1'b0;
      pool_last_q <= 1'b0;
      flat_vld_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      conv_row_q  <= conv_row_d;
      conv_col_q  <= conv_col_d;
      pool_row_q  <= pool_row_d;
      pool_col_q  <= pool_col_d;
      sub_q       <= sub_d;
      flat_q      <= flat_d;
      conv_vld_q  <= conv_vld_d;
      pool_vld_q  <= pool_vld_d;
      pool_last_q <= pool_last_d;
      flat_vld_q  <= flat_vld_d;
      done_q      <= done_d;
    end
  end

  assign phase      = state_q;
  assign busy       = (state_q == S_CONV) || (state_q == S_POOL) || (state_q == S_FLAT);
  assign conv_valid = conv_vld_q;
  assign conv_row   = conv_row_q;
  assign conv_col   = conv_col_q;
  assign pool_valid = pool_vld_q;
  assign pool_last  = pool_last_q;
  assign pool_row   = pool_row_q;
  assign pool_col   = pool_col_q;
  assign flat_valid = flat_vld_q;
  assign flat_index = flat_q;
  assign done       = done_q;

`ifdef CNN_SCHED_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_IDLE && state_d == S_CONV) begin
      stall_cnt_d = '0;
    end else if (busy && stall && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(negedge clk or negedge rst_cnn) begin
    if (!rst_cnn) stall_cnt_q <= '0;
    else          stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cnn_phase_scheduler.sv
// Directed bench for cnn_phase_scheduler: default 12x12 instance plus a 13-wide instance.
`timescale 1ns/1ps
module tb_cnn_phase_scheduler;

  logic clk = 1'b1;
  logic rst_cnn = 1'b0;
  logic start_n = 1'b1;
  logic weights_ready = 1'b0;
  logic stall = 1'b0;

  logic [2:0] phase, phase_b;
  logic       busy, busy_b;
  logic       conv_valid, conv_valid_b;
  logic [3:0] conv_row, conv_row_b, conv_col, conv_col_b;
  logic       pool_valid, pool_valid_b, pool_last, pool_last_b;
  logic [2:0] pool_row, pool_row_b, pool_col, pool_col_b;
  logic       flat_valid, flat_valid_b;
  logic [4:0] flat_index, flat_index_b;
  logic       done, done_b;
`ifdef CNN_SCHED_PERF_EN
  logic [15:0] stall_cycles, stall_cycles_b;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cnn_phase_scheduler dut (
    .clk(clk), .rst_cnn(rst_cnn), .start_n(start_n), .weights_ready(weights_ready),
    .stall(stall), .phase(phase), .busy(busy), .conv_valid(conv_valid),
    .conv_row(conv_row), .conv_col(conv_col), .pool_valid(pool_valid),
    .pool_last(pool_last), .pool_row(pool_row), .pool_col(pool_col),
    .flat_valid(flat_valid), .flat_index(flat_index), .done(done)
`ifdef CNN_SCHED_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  cnn_phase_scheduler #(.IMAGE_WIDTH(13)) dut_w13 (
    .clk(clk), .rst_cnn(rst_cnn), .start_n(start_n), .weights_ready(weights_ready),
    .stall(stall), .phase(phase_b), .busy(busy_b), .conv_valid(conv_valid_b),
    .conv_row(conv_row_b), .conv_col(conv_col_b), .pool_valid(pool_valid_b),
    .pool_last(pool_last_b), .pool_row(pool_row_b), .pool_col(pool_col_b),
    .flat_valid(flat_valid_b), .flat_index(flat_index_b), .done(done_b)
`ifdef CNN_SCHED_PERF_EN
    , .stall_cycles(stall_cycles_b)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // One active (falling) edge, then settle before sampling.
  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic run_seq(input int stall_len, input int exp_done, input string tag);
    int nconv = 0, npool = 0, nlast = 0, nflat = 0, ndone = 0, done_e = -1;
    int left = 0, wk = 0;
    int nconv13 = 0, nlast13 = 0, nflat13 = 0, ndone13 = 0, bad13 = 0;
    int lr = 0, lc = 0, lr13 = 0;
    bit armed;
    int er[4] = '{4, 4, 5, 5};
    int ec[4] = '{6, 7, 6, 7};
    int el[4] = '{0, 0, 0, 1};
    armed = (stall_len > 0);
    weights_ready = 1'b1;
    start_n = 1'b0;
    stall = 1'b0;
    step();
    start_n = 1'b1;
    chk({tag, "_start_phase"}, 32'(phase), 32'd1);
    chk({tag, "_start_addr"}, {conv_valid, conv_row, conv_col}, {1'b1, 4'd0, 4'd0});
    for (int e = 0; e <= 245; e++) begin
      if (e > 0) begin
        step();
        if (stall) begin
          chk({tag, "_stall_vld"}, 32'(conv_valid), 32'd0);
          chk({tag, "_stall_addr"}, {conv_row, conv_col}, {4'd4, 4'd7});
          left--;
        end
      end
      if (conv_valid) begin nconv++; lr = int'(conv_row); lc = int'(conv_col); end
      if (pool_valid) npool++;
      if (pool_last) nlast++;
      if (pool_valid && pool_row == 3'd2 && pool_col == 3'd3 && wk < 4) begin
        chk({tag, "_win_row"}, 32'(conv_row), 32'(er[wk]));
        chk({tag, "_win_col"}, 32'(conv_col), 32'(ec[wk]));
        chk({tag, "_win_last"}, 32'(pool_last), 32'(el[wk]));
        wk++;
      end
      if (flat_valid) begin
        chk({tag, "_flat_idx"}, 32'(flat_index), 32'(nflat));
        chk({tag, "_flat_src"}, 32'(flat_index), 32'(int'(pool_row) * 5 + int'(pool_col)));
        nflat++;
      end
      if (done) begin ndone++; done_e = e; end
      if (e == exp_done + 1) begin
        chk({tag, "_idle_phase"}, 32'(phase), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
      end
      if (conv_valid_b) begin nconv13++; lr13 = int'(conv_row_b); end
      if (pool_valid_b && conv_col_b == 4'd10) bad13++;
      if (pool_last_b) nlast13++;
      if (flat_valid_b) begin
        nflat13++;
        if (int'(flat_index_b) != int'(pool_row_b) * 5 + int'(pool_col_b)) bad13++;
      end
      if (done_b) ndone13++;
      if (armed && conv_valid && conv_row == 4'd4 && conv_col == 4'd7) begin
        left = stall_len;
        armed = 1'b0;
      end
      stall = (left > 0);
    end
    chk({tag, "_conv_cnt"}, 32'(nconv), 32'd100);
    chk({tag, "_conv_last"}, 32'(lr * 16 + lc), 32'(9 * 16 + 9));
    chk({tag, "_pool_cnt"}, 32'(npool), 32'd100);
    chk({tag, "_pool_last_cnt"}, 32'(nlast), 32'd25);
    chk({tag, "_win_seen"}, 32'(wk), 32'd4);
    chk({tag, "_flat_cnt"}, 32'(nflat), 32'd25);
    chk({tag, "_done_cnt"}, 32'(ndone), 32'd1);
    chk({tag, "_done_edge"}, 32'(done_e), 32'(exp_done));
    chk({tag, "_w13_conv_cnt"}, 32'(nconv13), 32'd110);
    chk({tag, "_w13_conv_lastrow"}, 32'(lr13), 32'd9);
    chk({tag, "_w13_bad"}, 32'(bad13), 32'd0);
    chk({tag, "_w13_last_cnt"}, 32'(nlast13), 32'd25);
    chk({tag, "_w13_flat_cnt"}, 32'(nflat13), 32'd25);
    chk({tag, "_w13_done_cnt"}, 32'(ndone13), 32'd1);
    chk({tag, "_w13_phase"}, 32'(phase_b), 32'd0);
`ifdef CNN_SCHED_PERF_EN
    chk({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(stall_len));
    chk({tag, "_w13_stall_cycles"}, 32'(stall_cycles_b), 32'(stall_len));
`endif
  endtask

  initial begin
    #12;
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", {conv_valid, conv_row, conv_col, pool_valid, pool_last, pool_row, pool_col,
                     flat_valid, flat_index, done}, 32'd0);
    chk("rst_w13", {phase_b, busy_b, done_b, flat_index_b}, 32'd0);
    rst_cnn = 1'b1;

    // Start requested without loaded weights must be ignored.
    start_n = 1'b0;
    weights_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("noweights_state", {phase, busy}, 32'd0);
    end

    run_seq(0, 225, "run1");
    run_seq(3, 228, "stall3");

    // Reset in the middle of POOL aborts without a done pulse.
    weights_ready = 1'b1;
    start_n = 1'b0;
    step();
    start_n = 1'b1;
    for (int i = 0; i < 150; i++) step();
    chk("mid_phase_pool", 32'(phase), 32'd2);
    #1 rst_cnn = 1'b0;
    #1;
    chk("mid_rst_outs", {phase, busy, conv_valid, conv_row, conv_col, pool_valid, pool_last,
                         pool_row, pool_col, flat_valid, flat_index, done}, 32'd0);
    step();
    chk("mid_rst_held", {phase, done, phase_b, done_b}, 32'd0);
    rst_cnn = 1'b1;
    step();
    chk("mid_rst_idle", {phase, busy, done}, 32'd0);
    run_seq(0, 225, "rerun");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cnn_phase_scheduler.md
# cnn_phase_scheduler

Sequencing controller for the CNN feature-extraction datapath. It takes a start request once the feature weight memory has been loaded. It then walks the convolution output positions, then the 2x2 max-pool windows, then the flatten index space, emitting one address/valid set per cycle. The convolution PE array, pooling comparators and flatten buffers are slaved to these addresses; all NUM_FEATURES features share one schedule and are processed in parallel. A stall input freezes the schedule for datapath backpressure.

## Interface
- IMAGE_WIDTH, 12, input image columns
- IMAGE_HEIGHT, 12, input image rows
- KERNEL_SIZE, 3, convolution kernel edge; stride fixed at 1
- Derived (localparam): CONV_W = IMAGE_WIDTH-KERNEL_SIZE+1, CONV_H = IMAGE_HEIGHT-KERNEL_SIZE+1, POOL_W = CONV_W>>1, POOL_H = CONV_H>>1, FLAT_N = POOL_W*POOL_H; RW = $clog2(CONV_H), CW = $clog2(CONV_W), FW = $clog2(FLAT_N)

Ports:
- clk  in  1  chip clock; all state updates on the falling edge
- rst_cnn  in  1  reset, asynchronous, active-low
- start_n  in  1  run request, active-low level
- weights_ready  in  1  weight memory loaded; start is qualified by it
- stall  in  1  active-high; holds all counters and suppresses valids
- phase  out  3  current state encoding
- busy  out  1  high in CONV, POOL, FLAT
- conv_valid  out  1  conv_row/conv_col address a new tile this cycle (CONV)
- conv_row  out  RW  convolution map row (CONV: tile origin; POOL: read address)
- conv_col  out  CW  convolution map column (same dual use)
- pool_valid  out  1  a pool-window element is addressed this cycle
- pool_last  out  1  final (4th) element of the window; pooled write strobe
- pool_row  out  $clog2(POOL_H)  pooled map row (POOL: write address; FLAT: read address)
- pool_col  out  $clog2(POOL_W)  pooled map column
- flat_valid  out  1  flat_index is valid
- flat_index  out  FW  flattened write index
- done  out  1  one-cycle completion pulse

## Operation
- States and phase encoding: IDLE=0, CONV=1, POOL=2, FLAT=3, DONE=4. All outputs are registered or decoded from registers; there are no combinational paths from inputs to outputs.
- IDLE: leaves for CONV when start_n==0 && weights_ready==1 at a falling edge. start_n low with weights_ready low is ignored.
- CONV: positions are visited in row-major order from (0,0) to (CONV_H-1, CONV_W-1), one per non-stalled cycle, with conv_valid=1. Accepting the last position transitions to POOL.
- POOL: pooled (r,c) windows are visited in row-major order. Each window takes 4 sub-steps that address conv positions (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1). pool_valid=1 on every sub-step; pool_last=1 on the 4th only. Odd CONV dimensions drop the trailing row/column (floor). The last element of window (POOL_H-1, POOL_W-1) transitions to FLAT.
- FLAT: flat_index runs 0..FLAT_N-1 with pool_row/pool_col giving the source; flat_index = pool_row*POOL_W + pool_col. The last index transitions to DONE.
- DONE: done=1 for exactly one cycle, then unconditionally returns to IDLE.
- start_n is ignored outside IDLE. If start_n is still held low on return to IDLE, a new run starts (minimum one IDLE cycle between runs).
- stall=1 in CONV/POOL/FLAT: all counters and the state hold, and all valids/pool_last are 0. Addresses keep their held values. stall has no effect in IDLE/DONE.
- Reset value of every output: 0 (phase=IDLE). Reset asserted mid-run aborts immediately to IDLE without a done pulse.

## Timing
- Edge E0 samples start → CONV; conv (0,0) is presented after E0.
- With no stall and default parameters: CONV covers 100 cycles (E1..E100), POOL covers 100 (E101..E200), and FLAT covers 25 (E201..E225). done is high between E225 and E226, and the block is back in IDLE after E226.
- Each stalled cycle delays every later event by exactly one cycle.
- Datapath contract: the write of a conv result for an address occurs on the edge that advances past it. Pool reads see the final conv map because POOL starts only after the last CONV write edge.

## Configuration
- CNN_SCHED_PERF_EN defined: adds output stall_cycles (16 bits), which counts cycles with stall=1 in CONV/POOL/FLAT. It saturates at 16'hFFFF, clears on the IDLE→CONV transition, holds through DONE/IDLE, and resets to 0.
- Not defined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Reset then start_n=0, weights_ready=1, stall=0 → conv_valid for 100 cycles (last at row 9, col 9), then 100 pool cycles with 25 pool_last pulses, then flat_index 0..24, then done one cycle at E225.
- start_n=0 with weights_ready=0 for 20 cycles → phase stays 0, busy=0; raising weights_ready → CONV on the next edge.
- stall=1 for 3 cycles at conv (4,7) → address held and conv_valid=0 for 3 cycles; done delayed to E228; PERF build reports stall_cycles=3.
- Pool window (2,3) → sub-addresses (4,6), (4,7), (5,6), (5,7); pool_last only on (5,7).
- rst_cnn low during POOL → all outputs 0 immediately, no done; a fresh start runs the full 226-cycle sequence.
- IMAGE_WIDTH=13 (CONV_W=11, POOL_W=5) → column 10 is never addressed in POOL; FLAT_N=25.
